imem_fetch_unit: RTL and testbench
==================================

// Module: imem_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface. Owns the DLX program counter and drives
//  ADDRESS/ENABLE towards the byte-addressable instruction memory, which answers with DATA_READY/DATA.
//  Buffers returned words with their PC in a small FIFO and hands them to decode (valid/ready).
//  Supports branch redirect with flush and flags a memory that never responds.
// PARAMETERS
//  ADDRESS_SIZE  16     address width (byte address)
//  WORD_SIZE     32     instruction width
//  PC_INC        4      bytes per instruction; PC step
//  RESET_PC      0      first fetch address after reset
//  TIMEOUT       15     max WAIT cycles without DATA_READY before error
//  DEPTH         2      output FIFO entries {pc, instr}
// PORTS
//  clk             in   1             clock, all state on posedge
//  rst             in   1             reset, asynchronous, active-low
//  ADDRESS         out  ADDRESS_SIZE  fetch address to instruction memory
//  ENABLE          out  1             memory read request
//  DATA_READY      in   1             memory response valid
//  DATA            in   WORD_SIZE     memory read data
//  redirect_valid  in   1             branch/jump taken: restart fetch at redirect_pc
//  redirect_pc     in   ADDRESS_SIZE  redirect target
//  ir_valid        out  1             FIFO head valid
//  ir              out  WORD_SIZE     FIFO head instruction
//  ir_pc           out  ADDRESS_SIZE  FIFO head PC
//  ir_ready        in   1             decode accepts head this cycle
//  fetch_error     out  1             timeout or misaligned redirect; held until redirect/reset
// BEHAVIOUR
//  - rst low (async): pc=RESET_PC, FIFO empty, state=REQ-pending GAP; ENABLE=0, ADDRESS=RESET_PC,
//    ir_valid=0, ir=0, ir_pc=0, fetch_error=0, timeout counter=0.
//  - States: GAP, REQ, WAIT, HOLD, ERR. Memory registers ADDRESS/ENABLE each edge, so
//    DATA_READY is sampled ONLY in WAIT; any DATA_READY in GAP/REQ/HOLD/ERR is stale, ignored.
//  - GAP : ENABLE=0. -> REQ if FIFO count<DEPTH, else HOLD. (Exactly one cycle.)
//  - REQ : ENABLE=1, ADDRESS=pc, counter cleared. -> WAIT.
//  - WAIT: ENABLE=1, ADDRESS=pc held stable. DATA_READY=1: push {pc,DATA}, pc+=PC_INC, -> GAP.
//          Else counter++; counter==TIMEOUT -> ERR.
//  - HOLD: ENABLE=0; -> REQ when count<DEPTH.
//  - ERR : ENABLE=0, fetch_error=1; leaves only via redirect or reset.
//  - At most one outstanding request; request issued only with a free FIFO slot, so a response
//    is never dropped. Steady-state throughput: 1 word / 3 cycles.
//  - PC arithmetic modulo 2**ADDRESS_SIZE (0xFFFC+4 -> 0x0000 at 16 bits).
//  - Redirect (any state, highest priority): FIFO flushed, pc<=redirect_pc, fetch_error cleared,
//    -> GAP. Same-cycle DATA_READY or ir_ready pop is discarded. If redirect_pc % PC_INC != 0:
//    FIFO flushed, -> ERR, fetch_error=1.
//  - FIFO: push and pop in the same cycle allowed (count unchanged); pop when ir_valid&&ir_ready;
//    ir/ir_pc are registered FIFO head, ir_valid = count!=0; FIFO order strictly by PC sequence.
// TESTING
//  1 Reset: rst low during WAIT -> same instant ENABLE=0, ir_valid=0, fetch_error=0; after
//    release first REQ drives ADDRESS=0x0000, ENABLE=1.
//  2 Stream: 1-cc memory, ram[0]=0x20010005, ram[4]=0x20020003, ram[8]=0x00221820, ir_ready=1
//    -> ir/ir_pc = (0x20010005,0x0000),(0x20020003,0x0004),(0x00221820,0x0008); ENABLE period 3.
//  3 Backpressure: ir_ready=0 -> two words buffered, ENABLE stays 0 (HOLD); ir_ready=1 ->
//    words delivered in order, fetch resumes at 0x0008, no word lost or duplicated.
//  4 Redirect in WAIT to 0x0100 with 1 word buffered -> ir_valid=0 next cycle, stale DATA_READY
//    in GAP ignored, next ADDRESS=0x0100, first ir_pc=0x0100.
//  5 Timeout: memory never asserts DATA_READY -> fetch_error=1 after 15 WAIT cycles, ENABLE=0;
//    redirect to 0x0000 -> fetch_error=0, fetch restarts at 0x0000.
//  6 Boundaries: redirect 0xFFFC -> ir_pc 0xFFFC then 0x0000; redirect 0x0102 -> ERR, fetch_error=1.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Instruction fetch initiator: owns the PC, issues one request at a time to a
// registered instruction memory and buffers returned words for decode.
module imem_fetch_unit #(
    parameter int ADDRESS_SIZE = 16,
    parameter int WORD_SIZE    = 32,
    parameter int PC_INC       = 4,
    parameter int RESET_PC     = 0,
    parameter int TIMEOUT      = 15,
    parameter int DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic                    ENABLE,
    input  logic                    DATA_READY,
    input  logic [WORD_SIZE-1:0]    DATA,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    ir_valid,
    output logic [WORD_SIZE-1:0]    ir,
    output logic [ADDRESS_SIZE-1:0] ir_pc,
    input  logic                    ir_ready,
    output logic                    fetch_error
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDRESS_SIZE-1:0] INC = ADDRESS_SIZE'(PC_INC);

    typedef enum logic [2:0] {S_GAP, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0]    instr;
    } entry_t;

    state_t                  state, state_nx;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [TMO_W-1:0]        tmo_cnt;
    entry_t                  fifo [DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count;
    logic                    has_room, misaligned, tmo_hit, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign has_room   = count < CNT_W'(DEPTH);
    assign misaligned = (redirect_pc % INC) != '0;
    assign tmo_hit    = (tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT);

    // Redirect wins over everything, so a same-cycle response or pop is dropped.
    assign push = (state == S_WAIT) && DATA_READY && !redirect_valid;
    assign pop  = ir_valid && ir_ready && !redirect_valid;

    assign ADDRESS  = pc;
    assign ir_valid = count != '0;
    assign ir       = fifo[rd_ptr].instr;
    assign ir_pc    = fifo[rd_ptr].pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_GAP;
        else      state <= state_nx;
    end

    // DATA_READY is only meaningful in WAIT; the memory's registered response
    // to the WAIT-cycle ENABLE lands in GAP and is deliberately ignored there.
    always_comb begin
        state_nx    = state;
        ENABLE      = 1'b0;
        fetch_error = 1'b0;
        case (state)
            S_GAP:  state_nx = has_room ? S_REQ : S_HOLD;
            S_HOLD: if (has_room) state_nx = S_REQ;
            S_REQ: begin
                ENABLE   = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                ENABLE = 1'b1;
                if (DATA_READY)   state_nx = S_GAP;
                else if (tmo_hit) state_nx = S_ERR;
            end
            S_ERR:   fetch_error = 1'b1;
            default: state_nx = S_GAP;
        endcase
        if (redirect_valid) state_nx = misaligned ? S_ERR : S_GAP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= ADDRESS_SIZE'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT && !DATA_READY) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Requests are only issued with a free slot, so push never meets a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{pc: pc, instr: DATA};
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: a registered 1-cycle memory, a transaction-level
// fetch model checked every cycle, and directed scenarios with literal expectations.
module tb_imem_fetch_unit;

    localparam int AW      = 16;
    localparam int WW      = 32;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [WW-1:0] instr;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ADDRESS;
    logic          ENABLE;
    logic          DATA_READY;
    logic [WW-1:0] DATA;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          ir_valid;
    logic [WW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_ready = 1'b0;
    logic          fetch_error;

    logic mem_on = 1'b1;
    logic mem_dr;
    int   vectors = 0;
    int   miscompares = 0;

    ent_t          m_q[$];
    ent_t          got[$];
    logic [AW-1:0] m_pc = '0;
    int            m_age = 0;   // 0 idle, 1 request cycle, n>=2 -> (n-1)th wait cycle
    bit            m_err = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_unit dut (
        .clk(clk), .rst(rst), .ADDRESS(ADDRESS), .ENABLE(ENABLE),
        .DATA_READY(DATA_READY), .DATA(DATA),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .fetch_error(fetch_error)
    );

    function automatic logic [WW-1:0] ram(input logic [AW-1:0] a);
        case (a)
            16'h0000: return 32'h2001_0005;
            16'h0004: return 32'h2002_0003;
            16'h0008: return 32'h0022_1820;
            default:  return {16'hA5A5, a};
        endcase
    endfunction

    // Memory registers ADDRESS/ENABLE and answers on the following cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_dr <= 1'b0;
            DATA   <= '0;
        end else begin
            mem_dr <= ENABLE && mem_on;
            DATA   <= ram(ADDRESS);
        end
    end
    assign DATA_READY = mem_dr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int sz;
        bit pop_ok;
        if (!rst) begin
            m_q.delete(); m_pc = '0; m_age = 0; m_err = 1'b0;
            return;
        end
        if (redirect_valid) begin
            m_q.delete();
            m_pc  = redirect_pc;
            m_err = (redirect_pc % 4) != 0;
            m_age = 0;
            return;
        end
        sz     = m_q.size();
        pop_ok = (sz != 0) && ir_ready;
        if (!m_err) begin
            if (m_age == 0) begin
                if (sz < DEPTH) m_age = 1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (DATA_READY) begin
                m_q.push_back({m_pc, ram(m_pc)});
                m_pc  = m_pc + 16'd4;
                m_age = 0;
            end else if (m_age - 1 == TIMEOUT) begin
                m_err = 1'b1;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
        if (pop_ok) void'(m_q.pop_front());
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("enable", ENABLE, m_age != 0);
            chk("address", ADDRESS, m_pc);
            chk("ir_valid", ir_valid, m_q.size() != 0);
            chk("fetch_error", fetch_error, m_err);
            if (m_q.size() != 0) begin
                chk("ir", ir, m_q[0].instr);
                chk("ir_pc", ir_pc, m_q[0].pc);
            end
            if (ir_valid && ir_ready && !redirect_valid) got.push_back({ir_pc, ir});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [AW-1:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_got(input string nm, input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) begin
            @(negedge clk); #1;
        end
        chk(nm, got.size() >= n, 1'b1);
    endtask

    task automatic wait_enable(input string nm, input int budget);
        for (int i = 0; i < budget && !ENABLE; i++) begin
            @(negedge clk); #1;
        end
        chk(nm, ENABLE, 1'b1);
    endtask

    function automatic ent_t got_at(input int k);
        ent_t e;
        e = 'x;
        if (got.size() > k) e = got[k];
        return e;
    endfunction

    initial begin
        int en;
        // reset state
        #2;
        chk("rst_enable", ENABLE, 1'b0);
        chk("rst_address", ADDRESS, 16'h0000);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 16'h0000);
        chk("rst_fetch_error", fetch_error, 1'b0);

        // reset asserted while a request is waiting
        @(posedge clk); #1;
        rst = 1'b1; mem_on = 1'b0;
        tick(2);
        chk("pre_rst_in_wait", ENABLE, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_enable", ENABLE, 1'b0);
        chk("async_rst_ir_valid", ir_valid, 1'b0);
        chk("async_rst_fetch_error", fetch_error, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; mem_on = 1'b1; ir_ready = 1'b1;
        wait_enable("first_req_timeout", 10);
        chk("first_req_address", ADDRESS, 16'h0000);

        // streaming with a 1-cycle memory
        wait_got("stream_timeout", 3, 30);
        chk("stream_w0", got_at(0), {16'h0000, 32'h2001_0005});
        chk("stream_w1", got_at(1), {16'h0004, 32'h2002_0003});
        chk("stream_w2", got_at(2), {16'h0008, 32'h0022_1820});
        en = 0;
        repeat (9) begin @(negedge clk); #1; en += int'(ENABLE); end
        chk("enable_duty_9cyc", en, 6);

        // backpressure: two words buffered, fetch holds
        ir_ready = 1'b0;
        redirect(16'h0000);
        tick(11);
        chk("bp_enable_held", ENABLE, 1'b0);
        chk("bp_ir_valid", ir_valid, 1'b1);
        chk("bp_head_pc", ir_pc, 16'h0000);
        chk("bp_next_addr", ADDRESS, 16'h0008);
        got.delete();
        ir_ready = 1'b1;
        wait_got("bp_drain_timeout", 3, 40);
        chk("bp_w0", got_at(0), {16'h0000, 32'h2001_0005});
        chk("bp_w1", got_at(1), {16'h0004, 32'h2002_0003});
        chk("bp_w2", got_at(2), {16'h0008, 32'h0022_1820});

        // irregular consumer, push and pop overlap
        for (int i = 0; i < 60; i++) begin
            ir_ready = (i % 4 != 1) && (i % 7 != 3);
            tick(1);
        end

        // redirect during WAIT with one word buffered
        ir_ready = 1'b0;
        redirect(16'h0000);
        tick(5);
        chk("rd_pre_in_wait", ENABLE, 1'b1);
        chk("rd_pre_one_buffered", ir_valid, 1'b1);
        ir_ready = 1'b1;
        redirect(16'h0100);
        chk("rd_flushed", ir_valid, 1'b0);
        chk("rd_gap_enable", ENABLE, 1'b0);
        got.delete();
        wait_enable("rd_req_timeout", 10);
        chk("rd_req_address", ADDRESS, 16'h0100);
        wait_got("rd_word_timeout", 1, 20);
        chk("rd_first_word", got_at(0), {16'h0100, 32'hA5A5_0100});

        // silent memory -> timeout error
        mem_on = 1'b0;
        redirect(16'h0200);
        en = 0;
        for (int i = 0; i < 40 && !fetch_error; i++) begin
            @(negedge clk); #1;
            if (!fetch_error && ENABLE) en++;
        end
        chk("tmo_error", fetch_error, 1'b1);
        chk("tmo_enable_cycles", en, 16);
        chk("tmo_enable_low", ENABLE, 1'b0);
        tick(3);
        chk("tmo_error_held", fetch_error, 1'b1);
        mem_on = 1'b1;
        redirect(16'h0000);
        chk("tmo_cleared", fetch_error, 1'b0);
        got.delete();
        wait_got("tmo_restart_timeout", 1, 20);
        chk("tmo_restart_pc", got_at(0).pc, 16'h0000);

        // address wrap and misaligned redirect
        redirect(16'hFFFC);
        got.delete();
        wait_got("wrap_timeout", 2, 30);
        chk("wrap_w0", got_at(0), {16'hFFFC, 32'hA5A5_FFFC});
        chk("wrap_w1", got_at(1), {16'h0000, 32'h2001_0005});
        redirect(16'h0102);
        chk("mis_error", fetch_error, 1'b1);
        chk("mis_enable", ENABLE, 1'b0);
        chk("mis_flushed", ir_valid, 1'b0);
        tick(4);
        chk("mis_error_held", fetch_error, 1'b1);
        redirect(16'h0000);
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
